nucleic_acid_seq_ctrl: RTL

//  Control-side sequencer driving the pneumatic (air_in) lines of the nucleic_acid_N reactor array.

---
 rtl/nucleic_acid_pkg.sv | 31 +++
 rtl/peristaltic_phase_gen.sv | 40 ++++
 rtl/nucleic_acid_seq_ctrl.sv | 90 +++++++++
 3 files changed

// File: rtl/nucleic_acid_pkg.sv
// nucleic_acid_pkg: shared state encoding, valve masks and pump phase table for the reactor sequencer
package nucleic_acid_pkg;
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    BEAD_LOAD = 3'd1,
    LYSIS     = 3'd2,
    MIX       = 3'd3,
    WASH      = 3'd4,
    ELUTE     = 3'd5,
    DONE      = 3'd6
  } state_t;
  // Valve vector order: lysis, wash, elute, horiz, vertical, loop_exit, bead_vtl, bead_trap, collection, waste
  localparam logic [9:0] VALVES_CLOSED = 10'b11_1111_1111;
  localparam logic [9:0] MASK_BEAD_LOAD = 10'b11_1011_0011;
  localparam logic [9:0] MASK_LYSIS = 10'b01_1101_1111;
  localparam logic [9:0] MASK_MIX = 10'b11_1101_1111;
  localparam logic [9:0] MASK_WASH = 10'b10_1110_1110;
  localparam logic [9:0] MASK_ELUTE = 10'b11_0110_1001;
  localparam logic [2:0] PUMP_IDLE = 3'b111;
  localparam logic [5:0][2:0] PUMP_TABLE = {3'b010, 3'b110, 3'b100, 3'b101, 3'b001, 3'b011};
  function automatic logic is_pumped(input state_t s);
    return s inside {MIX, WASH, ELUTE};
  endfunction
  function automatic logic [9:0] valve_mask(input state_t s);
    return s == BEAD_LOAD ? MASK_BEAD_LOAD :
           s == LYSIS     ? MASK_LYSIS :
           s == MIX       ? MASK_MIX :
           s == WASH      ? MASK_WASH :
           s == ELUTE     ? MASK_ELUTE : VALVES_CLOSED;
  endfunction
endpackage

// File: rtl/peristaltic_phase_gen.sv
// peristaltic_phase_gen: 6-phase pump valve waveform, PUMP_DIV clocks per phase, restarting at phase 0 when en rises.
// stroke_tick marks the final clock of each phase; with phase == 5 it closes a stroke.
module peristaltic_phase_gen
  import nucleic_acid_pkg::*;
#(
  parameter int PUMP_DIV = 4,
  parameter int CNT_W    = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic [2:0] phase,
  output logic [2:0] pump,
  output logic       stroke_tick
);
  logic             en_q;
  logic [CNT_W-1:0] div_q, div_d;
  logic [2:0]       phase_q, phase_d, pump_q, pump_d;
  always_comb begin
    stroke_tick = en_q && div_q == CNT_W'(PUMP_DIV - 1);
    div_d = (!en || !en_q || stroke_tick) ? '0 : div_q + 1'b1;
    phase_d = (!en || !en_q) ? 3'd0 : !stroke_tick ? phase_q : phase_q == 3'd5 ? 3'd0 : phase_q + 3'd1;
    pump_d = en ? PUMP_TABLE[phase_d] : PUMP_IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q    <= 1'b0;
      div_q   <= '0;
      phase_q <= 3'd0;
      pump_q  <= PUMP_IDLE;
    end else begin
      en_q    <= en;
      div_q   <= div_d;
      phase_q <= phase_d;
      pump_q  <= pump_d;
    end
  end
  assign phase = phase_q;
  assign pump  = pump_q;
endmodule

// File: rtl/nucleic_acid_seq_ctrl.sv
// nucleic_acid_seq_ctrl: extraction protocol sequencer driving the shared pneumatic valve lines of the reactor array.
// Outputs are registered from the next state so they change on the edge that enters a state.
module nucleic_acid_seq_ctrl
  import nucleic_acid_pkg::*;
#(
  parameter int PUMP_DIV      = 4,
  parameter int LOAD_CYCLES   = 16,
  parameter int MIX_STROKES   = 8,
  parameter int WASH_STROKES  = 4,
  parameter int ELUTE_STROKES = 4,
  parameter int CNT_W         = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  output logic       lysis_ctl,
  output logic       wash_ctl,
  output logic       elute_ctl,
  output logic       horiz_ctl,
  output logic       vertical_ctl,
  output logic       loop_exit_ctl,
  output logic       bead_vtl_ctl,
  output logic       bead_trap_ctl,
  output logic       collection_ctl,
  output logic       waste_ctl,
  output logic       pump1,
  output logic       pump2,
  output logic       pump3,
  output logic       busy,
  output logic       done,
  output logic [2:0] state_o
);
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_load;
  logic [9:0]       valves_q, valves_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             step, last, pump_en, stroke_tick;
  logic [2:0]       phase, pump;
  peristaltic_phase_gen #(
    .PUMP_DIV(PUMP_DIV),
    .CNT_W   (CNT_W)
  ) u_pump (
    .clk        (clk),
    .rst        (rst),
    .en         (pump_en),
    .phase      (phase),
    .pump       (pump),
    .stroke_tick(stroke_tick)
  );
  // One counter serves both dwell clocks and pump strokes; it holds remaining units minus one.
  always_comb begin
    step = is_pumped(state_q) ? (stroke_tick && phase == 3'd5) : state_q inside {BEAD_LOAD, LYSIS};
    last = step && cnt_q == '0;
    state_d = abort ? IDLE :
              state_q == IDLE ? (start ? BEAD_LOAD : IDLE) :
              state_q == DONE ? IDLE :
              last ? state_t'(state_q + 3'd1) : state_q;
    cnt_load = state_d inside {BEAD_LOAD, LYSIS} ? CNT_W'(LOAD_CYCLES - 1) :
               state_d == MIX   ? CNT_W'(MIX_STROKES - 1) :
               state_d == WASH  ? CNT_W'(WASH_STROKES - 1) :
               state_d == ELUTE ? CNT_W'(ELUTE_STROKES - 1) : '0;
    cnt_d = state_d != state_q ? cnt_load : step ? cnt_q - 1'b1 : cnt_q;
    pump_en = is_pumped(state_d);
    valves_d = valve_mask(state_d);
    busy_d = state_d != IDLE;
    done_d = state_d == DONE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      valves_q <= VALVES_CLOSED;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      valves_q <= valves_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end
  assign {lysis_ctl, wash_ctl, elute_ctl, horiz_ctl, vertical_ctl, loop_exit_ctl,
          bead_vtl_ctl, bead_trap_ctl, collection_ctl, waste_ctl} = valves_q;
  assign {pump1, pump2, pump3} = pump;
  assign busy    = busy_q;
  assign done    = done_q;
  assign state_o = state_q;
endmodule
